// File: rtl/pe_out_chan.sv
`default_nettype none
// ============================================================================
// Module   : pe_out_chan
// Brief    : In-order output channel downstream of the PE functional unit.
//            The FU reserves a slot, fills reservations in order, and filled
//            slots drain to the NoC in allocation order over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module pe_out_chan #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       fu_alloc,
  input  logic                       fu_valid,
  input  logic [DATA_WIDTH-1:0]      fu_out,
  output logic                       out_ready,
  output logic                       noc_valid,
  output logic [DATA_WIDTH-1:0]      noc_data,
  input  logic                       noc_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err_fill
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      filled;
  logic [PW-1:0]         rd_ptr;
  // Alloc and fill pointers carry an extra wrap bit so their difference
  // gives the reserved-but-unfilled count even when all slots are reserved.
  logic [PW:0]           alloc_ptr;
  logic [PW:0]           fill_ptr;
  logic [PW:0]           pending;
  logic                  alloc_fire;
  logic                  fill_fire;
  logic                  pop;

  // Handshake decodes; out_ready and noc_valid depend on registered state only.
  always_comb begin
    pending    = alloc_ptr - fill_ptr;
    out_ready  = (occupancy < OW'(DEPTH));
    noc_valid  = filled[rd_ptr];
    noc_data   = noc_valid ? mem[rd_ptr] : '0;
    alloc_fire = fu_alloc & out_ready;
    // With nothing pending, a same-cycle alloc provides the slot to fill;
    // it sits at fill_ptr because alloc_ptr == fill_ptr in that case.
    fill_fire  = fu_valid & ((pending != '0) | alloc_fire);
    pop        = noc_valid & noc_ready;
  end

  // Slot data storage; stale contents are masked by the filled flags.
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      mem[fill_ptr[PW-1:0]] <= fu_out;
    end
  end

  // Pointers, filled flags, occupancy and sticky error; clear acts as reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr    <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      filled    <= '0;
      occupancy <= '0;
      err_fill  <= 1'b0;
    end else begin
      if (alloc_fire) begin
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (fill_fire) begin
        fill_ptr <= fill_ptr + 1'b1;
      end else if (fu_valid) begin
        err_fill <= 1'b1;
      end
      // Fill and pop never target the same slot: the fill slot is unfilled,
      // the pop slot is filled, so both updates can be applied together.
      for (int i = 0; i < DEPTH; i++) begin
        if (fill_fire && (PW'(i) == fill_ptr[PW-1:0])) begin
          filled[i] <= 1'b1;
        end else if (pop && (PW'(i) == rd_ptr)) begin
          filled[i] <= 1'b0;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({alloc_fire, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_out_chan.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_out_chan
// Brief    : Directed self-checking bench for pe_out_chan (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_out_chan;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  clear;
  logic                  fu_alloc;
  logic                  fu_valid;
  logic [DATA_WIDTH-1:0] fu_out;
  logic                  out_ready;
  logic                  noc_valid;
  logic [DATA_WIDTH-1:0] noc_data;
  logic                  noc_ready;
  logic [2:0]            occupancy;
  logic                  err_fill;

  int tests_run = 0;
  int tests_failed = 0;

  pe_out_chan #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .fu_alloc  (fu_alloc),
    .fu_valid  (fu_valid),
    .fu_out    (fu_out),
    .out_ready (out_ready),
    .noc_valid (noc_valid),
    .noc_data  (noc_data),
    .noc_ready (noc_ready),
    .occupancy (occupancy),
    .err_fill  (err_fill)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; fu_alloc = 1'b1; fu_valid = 1'b0;
    fu_out = '0; noc_ready = 1'b0;

    // 1 Reset held two cycles with fu_alloc asserted
    step(); step();
    check("rst_noc_valid", 32'(noc_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_ready", 32'(out_ready), 32'd1);
    check("rst_err_fill",  32'(err_fill),  32'd0);
    check("rst_noc_data",  noc_data,       32'd0);
    rst_n = 1'b1; fu_alloc = 1'b0;

    // 2 Alloc and fill in the same cycle
    fu_alloc = 1'b1; fu_valid = 1'b1; fu_out = 32'hA5; noc_ready = 1'b1;
    step();
    fu_alloc = 1'b0; fu_valid = 1'b0;
    check("t2_noc_valid", 32'(noc_valid), 32'd1);
    check("t2_noc_data",  noc_data,       32'hA5);
    check("t2_occ1",      32'(occupancy), 32'd1);
    step();
    check("t2_occ0",      32'(occupancy), 32'd0);
    check("t2_valid0",    32'(noc_valid), 32'd0);

    // 3 Four reservations fill the channel; fifth refused
    noc_ready = 1'b0; fu_alloc = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("t3_occ_full",  32'(occupancy), 32'd4);
    check("t3_ready0",    32'(out_ready), 32'd0);
    check("t3_unfilled",  32'(noc_valid), 32'd0);
    step();
    check("t3_5th_alloc", 32'(occupancy), 32'd4);
    fu_alloc = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      fu_valid = 1'b1; fu_out = 32'(i);
      step();
      check("t3_head_after_fill", noc_data, 32'd1);
    end
    fu_valid = 1'b0;
    check("t3_valid", 32'(noc_valid), 32'd1);

    // 4 Full: pop and alloc together, alloc refused this cycle
    noc_ready = 1'b1; fu_alloc = 1'b1;
    step();
    check("t4_occ3",   32'(occupancy), 32'd3);
    check("t4_ready1", 32'(out_ready), 32'd1);
    check("t4_head2",  noc_data,       32'd2);
    noc_ready = 1'b0;
    step();
    check("t4_occ4",   32'(occupancy), 32'd4);
    fu_alloc = 1'b0; noc_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      check("t4_drain_data", noc_data, 32'(i));
      step();
    end
    check("t4_head_unfilled", 32'(noc_valid), 32'd0);
    check("t4_occ1",          32'(occupancy), 32'd1);
    fu_valid = 1'b1; fu_out = 32'd5;
    step();
    fu_valid = 1'b0;
    check("t4_late_fill", noc_data, 32'd5);
    step();
    check("t4_empty", 32'(occupancy), 32'd0);

    // 5 Fill with no reservation sets sticky error
    fu_valid = 1'b1; fu_out = 32'hDEAD;
    step();
    fu_valid = 1'b0;
    check("t5_err",      32'(err_fill),  32'd1);
    check("t5_novalid",  32'(noc_valid), 32'd0);
    check("t5_occ",      32'(occupancy), 32'd0);
    step();
    check("t5_err_sticky", 32'(err_fill), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5_err_cleared", 32'(err_fill), 32'd0);

    // 6 Clear mid-operation, then wrap pointers
    noc_ready = 1'b0; fu_alloc = 1'b1;
    step(); step();
    fu_alloc = 1'b0; fu_valid = 1'b1; fu_out = 32'h77;
    step();
    fu_valid = 1'b0;
    check("t6_pre_valid", 32'(noc_valid), 32'd1);
    check("t6_pre_occ",   32'(occupancy), 32'd2);
    clear = 1'b1; fu_alloc = 1'b1; fu_valid = 1'b1; noc_ready = 1'b1;
    step();
    clear = 1'b0; fu_alloc = 1'b0; noc_ready = 1'b0;
    check("t6_clr_occ",   32'(occupancy), 32'd0);
    check("t6_clr_valid", 32'(noc_valid), 32'd0);
    check("t6_clr_err",   32'(err_fill),  32'd0);
    step();
    fu_valid = 1'b0;
    check("t6_err_after_clear", 32'(err_fill), 32'd1);
    noc_ready = 1'b1; fu_alloc = 1'b1; fu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fu_out = 32'h100 + 32'(i);
      step();
      check("t6_wrap_data", noc_data,       32'h100 + 32'(i));
      check("t6_wrap_occ",  32'(occupancy), 32'd1);
    end
    fu_alloc = 1'b0; fu_valid = 1'b0;
    step();
    check("t6_final_occ", 32'(occupancy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
